// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshakes and full backpressure.
// Optional SHIFT_PIPE_STICKY_EN adds out_sticky: the OR of bits shifted out past the LSB for SRL/SRA.
module shift_pipe #(
   parameter int N           = 32,
   parameter int LVL_PER_STG = 1,
   parameter int TAG_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_shamt,
   input  logic [1:0]           in_op,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
`ifdef SHIFT_PIPE_STICKY_EN
   output logic                 out_sticky,
`endif
   output logic [TAG_W-1:0]     out_tag
);

   localparam int L = $clog2(N);
   localparam int S = (L + LVL_PER_STG - 1) / LVL_PER_STG;

   // One conditional shift by sh = 2^k; sign is the operand's original MSB.
   function automatic logic [N-1:0] shift_lvl(input logic [N-1:0] d, input logic [1:0] op,
                                              input logic sign, input int sh);
      logic [N-1:0] fill;
      fill = sign ? ~({N{1'b1}} >> sh) : '0;
      case (op)
         2'b00:   shift_lvl = d << sh;
         2'b01:   shift_lvl = d >> sh;
         2'b10:   shift_lvl = (d >> sh) | fill;
         default: shift_lvl = (d >> sh) | (d << (N - sh));
      endcase
   endfunction

`ifdef SHIFT_PIPE_STICKY_EN
   function automatic logic lost_bits(input logic [N-1:0] d, input logic [1:0] op, input int sh);
      lost_bits = ((op == 2'b01) || (op == 2'b10)) && (|(d & ~({N{1'b1}} << sh)));
   endfunction
`endif

   logic [S-1:0] vld;
   logic [S-1:0] ready;

   for (genvar gi = 0; gi < S; gi++) begin : g_stg
      localparam int LO = gi * LVL_PER_STG;
      localparam int HI = (LO + LVL_PER_STG > L) ? L : LO + LVL_PER_STG;

      logic             src_valid;
      logic [N-1:0]     src_data;
      logic [1:0]       src_op;
      logic [L-1:0]     src_shamt;
      logic             src_sign;
      logic [TAG_W-1:0] src_tag;
      logic [N-1:0]     nxt_data;
      logic             valid_reg;
      logic [N-1:0]     data_reg;
      logic [TAG_W-1:0] tag_reg;
`ifdef SHIFT_PIPE_STICKY_EN
      logic             src_sticky;
      logic             nxt_sticky;
      logic             sticky_reg;
`endif

      if (gi == 0) begin : g_src
         assign src_valid = in_valid;
         assign src_data  = in_data;
         assign src_op    = in_op;
         assign src_shamt = in_shamt;
         assign src_sign  = in_data[N-1];
         assign src_tag   = in_tag;
`ifdef SHIFT_PIPE_STICKY_EN
         assign src_sticky = 1'b0;
`endif
      end else begin : g_src
         assign src_valid = g_stg[gi-1].valid_reg;
         assign src_data  = g_stg[gi-1].data_reg;
         assign src_op    = g_stg[gi-1].g_ctl.op_reg;
         assign src_shamt = g_stg[gi-1].g_ctl.shamt_reg;
         assign src_sign  = g_stg[gi-1].g_ctl.sign_reg;
         assign src_tag   = g_stg[gi-1].tag_reg;
`ifdef SHIFT_PIPE_STICKY_EN
         assign src_sticky = g_stg[gi-1].sticky_reg;
`endif
      end

      always_comb begin
         nxt_data = src_data;
`ifdef SHIFT_PIPE_STICKY_EN
         nxt_sticky = src_sticky;
`endif
         for (int k = LO; k < HI; k++) begin
            if (src_shamt[k]) begin
`ifdef SHIFT_PIPE_STICKY_EN
               nxt_sticky = nxt_sticky | lost_bits(nxt_data, src_op, 1 << k);
`endif
               nxt_data = shift_lvl(nxt_data, src_op, src_sign, 1 << k);
            end
         end
      end

      // A stage may load when it is empty or everything downstream of it can advance.
      assign vld[gi]   = valid_reg;
      assign ready[gi] = out_ready || !(&vld[S-1:gi]);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            tag_reg   <= '0;
`ifdef SHIFT_PIPE_STICKY_EN
            sticky_reg <= 1'b0;
`endif
         end else if (ready[gi]) begin
            valid_reg <= src_valid;
            if (src_valid) begin
               data_reg <= nxt_data;
               tag_reg  <= src_tag;
`ifdef SHIFT_PIPE_STICKY_EN
               sticky_reg <= nxt_sticky;
`endif
            end
         end
      end

      // Control for later levels is only needed by stages that still have levels after them.
      if (gi < S - 1) begin : g_ctl
         logic [1:0]   op_reg;
         logic [L-1:0] shamt_reg;
         logic         sign_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               op_reg    <= '0;
               shamt_reg <= '0;
               sign_reg  <= 1'b0;
            end else if (ready[gi] && src_valid) begin
               op_reg    <= src_op;
               shamt_reg <= src_shamt;
               sign_reg  <= src_sign;
            end
         end
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = g_stg[S-1].valid_reg;
   assign out_data  = g_stg[S-1].data_reg;
   assign out_tag   = g_stg[S-1].tag_reg;
`ifdef SHIFT_PIPE_STICKY_EN
   assign out_sticky = g_stg[S-1].sticky_reg;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: three instances (S=5, 3, 1); table vectors plus backpressure and reset sequences.
// Sticky checks are compiled in when SHIFT_PIPE_STICKY_EN is defined.
module tb_shift_pipe;

   localparam logic [1:0] OP_SLL = 2'd0;
   localparam logic [1:0] OP_SRL = 2'd1;
   localparam logic [1:0] OP_SRA = 2'd2;
   localparam logic [1:0] OP_ROR = 2'd3;

   logic        clk;
   logic        rst;
   logic        iv   [3];
   logic        ir   [3];
   logic [31:0] idat [3];
   logic [4:0]  ish  [3];
   logic [1:0]  iop  [3];
   logic [3:0]  itg  [3];
   logic        ov   [3];
   logic        ordy [3];
   logic [31:0] odat [3];
   logic [3:0]  otg  [3];
`ifdef SHIFT_PIPE_STICKY_EN
   logic        ost  [3];
`endif

   int checks   = 0;
   int failures = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      shift_pipe #(
         .N(32),
         .LVL_PER_STG((gi == 0) ? 1 : (gi == 1) ? 2 : 5),
         .TAG_W(4)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .in_valid(iv[gi]),
         .in_ready(ir[gi]),
         .in_data(idat[gi]),
         .in_shamt(ish[gi]),
         .in_op(iop[gi]),
         .in_tag(itg[gi]),
         .out_valid(ov[gi]),
         .out_ready(ordy[gi]),
         .out_data(odat[gi]),
`ifdef SHIFT_PIPE_STICKY_EN
         .out_sticky(ost[gi]),
`endif
         .out_tag(otg[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  sh;
      logic [31:0] exp;
      logic        st;
   } vec_t;

   vec_t vt [17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
      case (op)
         OP_SLL:  model = d << s;
         OP_SRL:  model = d >> s;
         OP_SRA:  model = 32'($signed(d) >>> s);
         default: model = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
      endcase
   endfunction

   // Issues one op at posedge+1 with out_ready high and measures acceptance-to-out_valid latency.
   task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh,
                         input logic [3:0] tag, input logic [31:0] exp, input logic exp_st, input int exp_lat);
      int lat;
      check("in_ready_idle", 64'(ir[d]), 64'd1);
      iv[d] = 1'b1; iop[d] = op; idat[d] = data; ish[d] = sh; itg[d] = tag;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      lat = 1;
      while (!ov[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("op dut=%0d op=%0d data=%h sh=%0d -> out=%h tag=%0d lat=%0d", d, op, data, sh, odat[d], otg[d], lat);
      check("latency", 64'(lat), 64'(exp_lat));
      check("out_data", 64'(odat[d]), 64'(exp));
      check("out_tag", 64'(otg[d]), 64'(tag));
`ifdef SHIFT_PIPE_STICKY_EN
      check("out_sticky", 64'(ost[d]), 64'(exp_st));
`else
      if (exp_st === 1'bx) check("sticky_vec", 64'(exp_st), 64'd0);
`endif
      @(posedge clk); #1;
      check("drained", 64'(ov[d]), 64'd0);
   endtask

   initial begin
      logic [31:0] bp_data [8];
      logic [31:0] bp_exp  [8];
      int acc, cons, waitc;
      logic blk_seen;

      vt[0]  = '{OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
      vt[1]  = '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
      vt[2]  = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
      vt[3]  = '{OP_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0};
      vt[4]  = '{OP_SLL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0};
      vt[5]  = '{OP_SRL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0};
      vt[6]  = '{OP_SRA, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0};
      vt[7]  = '{OP_ROR, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0};
      vt[8]  = '{OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1};
      vt[9]  = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
      vt[10] = '{OP_ROR, 32'h8000_0001, 5'd1,  32'hC000_0000, 1'b0};
      vt[11] = '{OP_SLL, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F00, 1'b0};
      vt[12] = '{OP_SRL, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F0F, 1'b0};
      vt[13] = '{OP_ROR, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0};
      vt[14] = '{OP_SRL, 32'h0000_0011, 5'd4,  32'h0000_0001, 1'b1};
      vt[15] = '{OP_SRL, 32'h0000_0010, 5'd4,  32'h0000_0001, 1'b0};
      vt[16] = '{OP_SLL, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0};

      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; idat[i] = '0; ish[i] = '0; iop[i] = '0; itg[i] = '0; ordy[i] = 1'b1;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(ov[0]), 64'd0);
      check("rst_out_data", 64'(odat[0]), 64'd0);
      check("rst_out_tag", 64'(otg[0]), 64'd0);
`ifdef SHIFT_PIPE_STICKY_EN
      check("rst_out_sticky", 64'(ost[0]), 64'd0);
`endif
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) check("in_ready_after_rst", 64'(ir[i]), 64'd1);

      // Table vectors on the S=5 instance.
      for (int i = 0; i < 17; i++)
         run_op(0, vt[i].op, vt[i].data, vt[i].sh, 4'(i), vt[i].exp, vt[i].st, 5);

      // Shallower pipelines.
      run_op(1, OP_SRA, 32'h8000_0001, 5'd1, 4'd9, 32'hC000_0000, 1'b1, 3);
      run_op(2, OP_SRA, 32'h8000_0001, 5'd1, 4'd10, 32'hC000_0000, 1'b1, 1);
      run_op(2, OP_ROR, 32'h1234_5678, 5'd8, 4'd11, 32'h7812_3456, 1'b0, 1);

      // Backpressure: 8 back-to-back ops, out_ready low during cycles 6..9.
      for (int i = 0; i < 8; i++) begin
         bp_data[i] = 32'h9ABC_DEF0 ^ (32'h1111_1111 * 32'(i));
         bp_exp[i]  = model(2'(i), bp_data[i], 5'(i * 3 + 1));
      end
      acc = 0; cons = 0; blk_seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
         ordy[0] = !(t >= 6 && t <= 9);
         if (acc < 8) begin
            iv[0] = 1'b1; iop[0] = 2'(acc); idat[0] = bp_data[acc];
            ish[0] = 5'(acc * 3 + 1); itg[0] = 4'(acc);
         end else begin
            iv[0] = 1'b0;
         end
         #3;
         if (iv[0] && !ir[0] && !blk_seen) begin
            blk_seen = 1'b1;
            check("bp_inflight_at_block", 64'(acc - cons), 64'd5);
            check("bp_block_cycle", 64'(t), 64'd6);
         end
         if (ov[0]) begin
            if (cons < 8) begin
               check("bp_out_data", 64'(odat[0]), 64'(bp_exp[cons]));
               check("bp_out_tag", 64'(otg[0]), 64'(cons));
            end else begin
               check("bp_extra_output", 64'(ov[0]), 64'd0);
            end
         end
         if (ov[0] && ordy[0]) begin
            $display("bp out tag=%0d data=%h cycle=%0d", otg[0], odat[0], t);
            cons++;
         end
         if (iv[0] && ir[0]) acc++;
         @(posedge clk); #1;
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      check("bp_blocked_seen", 64'(blk_seen), 64'd1);
      check("bp_accepted", 64'(acc), 64'd8);
      check("bp_consumed", 64'(cons), 64'd8);

      // Reset mid-flight with 3 ops in the pipe and the oldest held at the output.
      for (int i = 0; i < 3; i++) begin
         iv[0] = 1'b1; iop[0] = OP_SLL; idat[0] = 32'(i + 1); ish[0] = 5'd1; itg[0] = 4'(i + 12);
         @(posedge clk); #1;
      end
      iv[0] = 1'b0;
      waitc = 0;
      while (!ov[0] && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("rst_pre_valid", 64'(ov[0]), 64'd1);
      ordy[0] = 1'b0;
      rst = 1'b0;
      #1;
      $display("reset pulse mid-flight at %0t", $time);
      check("rst_mid_out_valid", 64'(ov[0]), 64'd0);
      check("rst_mid_out_data", 64'(odat[0]), 64'd0);
      check("rst_mid_out_tag", 64'(otg[0]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      ordy[0] = 1'b1;
      #1;
      check("rst_mid_in_ready", 64'(ir[0]), 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("rst_no_ghost", 64'(ov[0]), 64'd0);
      end
      run_op(0, OP_SRL, 32'h0000_00F0, 5'd4, 4'd5, 32'h0000_000F, 1'b0, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the datapath. Supports four modes: SLL, SRL, SRA and ROR.
- Built from log2(N) conditional shift levels. Pipeline registers sit between groups of levels.
- Uses valid/ready handshakes at both ends, with full backpressure.
- Intended to replace single-cycle shift units where timing on wide N fails.

Parameters:
- N, 32, data width; power of two, 8..64.
- LVL_PER_STG, 1, shift levels per pipeline stage; 1..$clog2(N).
- TAG_W, 4, width of a sideband tag carried with each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  N  operand.
- in_shamt  input  $clog2(N)  shift amount.
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  sideband tag; returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Shift levels:
  - L = $clog2(N) levels. Level k shifts by 2^k when shamt[k]=1, otherwise passes the value through.
  - Levels are applied in order k=0..L-1.
- Pipeline depth and latency:
  - S = ceil(L/LVL_PER_STG) register stages. Each stage applies its levels combinationally and then registers the result.
  - Latency from an accepted input (in_valid&&in_ready) to out_valid is exactly S cycles when out_ready stays 1.
  - Example: N=32, LVL_PER_STG=1 gives S=5.
- What each stage carries: valid, data, op, remaining shamt bits, tag.
- Mode fill rules:
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with the original bit N-1. The sign is captured at input and carried down the pipe.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Handshake:
  - ready_i = !valid_i || ready_(i+1), with ready_S = out_ready. in_ready = ready_1 (combinational chain).
  - Bubbles collapse. Throughput is one operation per cycle when unstalled.
  - Stall: while out_valid && !out_ready, out_data and out_tag hold stable. No operation is dropped or duplicated, and ordering is strict FIFO.
  - in_valid with in_ready=0: nothing is captured. The producer must hold its inputs.
- Reset (rst=0):
  - All stage valids clear immediately, asynchronously.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 once reset is released.
  - Reset mid-operation discards every in-flight operation; no partial results appear afterwards.
- Boundary cases:
  - shamt=0: result equals in_data for all modes.
  - shamt=N-1 is the maximum.
  - Simultaneous accept at the input and drain at the output while the pipe is full is legal and sustains 1/cycle.

Optional Feature:
- Macro: SHIFT_PIPE_STICKY_EN.
- When defined:
  - Adds output out_sticky (1 bit), aligned with out_data and out_valid.
  - For SRL and SRA, out_sticky is the OR of all bits shifted out past the LSB. It is accumulated per level and carried through the stages.
  - For SLL and ROR, out_sticky is 0.
  - Reset value is 0. The value holds during a stall.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=32, LVL_PER_STG=1, out_ready=1, single ops:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRL 0x80000000 by 31 -> 0x00000001.
  - SLL 0x00000001 by 31 -> 0x80000000.
  - ROR 0x12345678 by 8 -> 0x78123456.
  - Each out_valid rises exactly 5 cycles after acceptance.
- shamt=0 with each op on 0xA5A5A5A5 -> 0xA5A5A5A5. Tags 0..3 return in order.
- Backpressure: issue 8 back-to-back ops with tags 0..7; out_ready=0 for cycles 6..9.
  - in_ready drops once 5 ops are in flight.
  - out_data/out_tag stay stable while stalled.
  - All 8 results arrive in order with no loss or duplication.
- Reset mid-flight: 3 ops in the pipe, pulse rst=0 for 1 cycle.
  - out_valid=0 immediately and stays 0 until new ops are issued.
  - A following op SRL 0xF0 by 4 -> 0x0F after 5 cycles.
- LVL_PER_STG=2 (S=3) and LVL_PER_STG=5 (S=1): SRA 0x80000001 by 1 -> 0xC0000000, with latency 3 and 1 cycles respectively.
- SHIFT_PIPE_STICKY_EN defined:
  - SRL 0x00000011 by 4 -> data 0x1, sticky 1.
  - SRL 0x00000010 by 4 -> sticky 0.
  - SLL 0xFFFFFFFF by 4 -> sticky 0.
